// File: rtl/mm_spart_pkg.sv
// Shared constants and types for the memory-mapped SPART: register offsets,
// FSM state encodings and the divisor floor.
package mm_spart_pkg;

    localparam int unsigned REG_W = 16;

    localparam logic [REG_W-1:0] OFF_DATA    = 16'd0;
    localparam logic [REG_W-1:0] OFF_STATUS  = 16'd1;
    localparam logic [REG_W-1:0] OFF_DIVISOR = 16'd2;

    localparam logic [REG_W-1:0] MIN_DIV = 16'd16;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Divisors below the floor are clamped so the half-bit sample point stays meaningful.
    function automatic logic [REG_W-1:0] eff_div(input logic [REG_W-1:0] d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

endpackage

// File: rtl/spart_fifo.sv
// Synchronous FIFO with registered count/full/empty; a pop on empty is ignored and
// a push on full is accepted only when a pop frees a slot in the same cycle.
module spart_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             head_c,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_next;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head_c  = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count_next;
            full  <= (count_next == CNT_W'(DEPTH));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/mm_spart.sv
// Memory-mapped SPART: three-register CPU window over TX/RX byte FIFOs, an 8N1
// transmitter and a receiver with synchronizer, framing and overrun detection.
module mm_spart
    import mm_spart_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = 16'hC004,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] DB_RESET   = 16'd434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr,
    input  logic        mm_re,
    input  logic        mm_we,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        TX,
    input  logic        RX
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [15:0] ADDR_DATA    = BASE_ADDR + OFF_DATA;
    localparam logic [15:0] ADDR_STATUS  = BASE_ADDR + OFF_STATUS;
    localparam logic [15:0] ADDR_DIVISOR = BASE_ADDR + OFF_DIVISOR;

    logic sel_data, sel_status, sel_div;
    logic rd_status, wr_data, wr_div;
    logic [15:0] divisor;

    logic             tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]       tx_head;
    logic [CNT_W-1:0] tx_count, tx_free;

    logic             rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]       rx_head;
    logic [CNT_W-1:0] rx_count;

    logic frame_err, overrun, fe_set, ov_set;

    assign sel_data   = (addr == ADDR_DATA);
    assign sel_status = (addr == ADDR_STATUS);
    assign sel_div    = (addr == ADDR_DIVISOR);
    assign rd_status  = mm_re && sel_status;
    assign wr_data    = mm_we && sel_data;
    assign wr_div     = mm_we && sel_div;
    assign rx_pop     = mm_re && sel_data && !rx_empty;
    assign tx_push    = wr_data && (!tx_full || tx_pop);
    assign tx_free    = CNT_W'(FIFO_DEPTH) - tx_count;
    assign ov_set     = rx_push && rx_full && !rx_pop;

    always_comb begin
        rdata = '0;
        if (mm_re) begin
            if (sel_data && !rx_empty) begin
                rdata = {8'h00, rx_head};
            end else if (sel_status) begin
                rdata = {6'b0, frame_err, overrun, 4'(tx_free), 4'(rx_count)};
            end else if (sel_div) begin
                rdata = divisor;
            end
        end
    end

    // Divisor register and sticky error flags; a new error outranks the read-clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divisor   <= DB_RESET;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (wr_div) divisor <= wdata;
            if (fe_set)         frame_err <= 1'b1;
            else if (rd_status) frame_err <= 1'b0;
            if (ov_set)         overrun <= 1'b1;
            else if (rd_status) overrun <= 1'b0;
        end
    end

    spart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (tx_push),
        .pop    (tx_pop),
        .wdata  (wdata[7:0]),
        .head_c (tx_head),
        .full   (tx_full),
        .empty  (tx_empty),
        .count  (tx_count)
    );

    logic [7:0] rx_shift;

    spart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (rx_push),
        .pop    (rx_pop),
        .wdata  (rx_shift),
        .head_c (rx_head),
        .full   (rx_full),
        .empty  (rx_empty),
        .count  (rx_count)
    );

    // ---------------- transmitter ----------------
    tx_state_t   tx_state, tx_state_next;
    logic [15:0] tx_div, tx_div_next, tx_cnt, tx_cnt_next;
    logic [2:0]  tx_bit, tx_bit_next;
    logic [7:0]  tx_shift, tx_shift_next;
    logic        tx_line, tx_line_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_div   <= DB_RESET;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_next;
            tx_div   <= tx_div_next;
            tx_cnt   <= tx_cnt_next;
            tx_bit   <= tx_bit_next;
            tx_shift <= tx_shift_next;
            tx_line  <= tx_line_next;
        end
    end

    // Line value is computed one cycle ahead so TX comes straight from a flop.
    always_comb begin
        tx_state_next = tx_state;
        tx_div_next   = tx_div;
        tx_cnt_next   = tx_cnt + 16'd1;
        tx_bit_next   = tx_bit;
        tx_shift_next = tx_shift;
        tx_line_next  = tx_line;
        tx_pop        = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_next  = '0;
                tx_line_next = 1'b1;
                if (!tx_empty) begin
                    tx_pop        = 1'b1;
                    tx_state_next = TX_START;
                    tx_div_next   = eff_div(divisor);
                    tx_shift_next = tx_head;
                    tx_line_next  = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt == tx_div - 16'd1) begin
                    tx_cnt_next   = '0;
                    tx_bit_next   = '0;
                    tx_line_next  = tx_shift[0];
                    tx_state_next = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt == tx_div - 16'd1) begin
                    tx_cnt_next = '0;
                    if (tx_bit == 3'd7) begin
                        tx_line_next  = 1'b1;
                        tx_state_next = TX_STOP;
                    end else begin
                        tx_bit_next   = tx_bit + 3'd1;
                        tx_shift_next = {1'b0, tx_shift[7:1]};
                        tx_line_next  = tx_shift[1];
                    end
                end
            end
            TX_STOP: begin
                if (tx_cnt == tx_div - 16'd1) begin
                    tx_cnt_next   = '0;
                    tx_state_next = TX_IDLE;
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    assign TX = tx_line;

    // ---------------- receiver ----------------
    logic rx_meta, rx_sync, rx_prev, rx_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall = rx_prev && !rx_sync;

    rx_state_t   rx_state, rx_state_next;
    logic [15:0] rx_div, rx_div_next, rx_cnt, rx_cnt_next;
    logic [2:0]  rx_bit, rx_bit_next;
    logic [7:0]  rx_shift_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_div   <= DB_RESET;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_next;
            rx_div   <= rx_div_next;
            rx_cnt   <= rx_cnt_next;
            rx_bit   <= rx_bit_next;
            rx_shift <= rx_shift_next;
        end
    end

    // Start bit is checked mid-bit; data and stop are then sampled a full period apart.
    always_comb begin
        rx_state_next = rx_state;
        rx_div_next   = rx_div;
        rx_cnt_next   = rx_cnt + 16'd1;
        rx_bit_next   = rx_bit;
        rx_shift_next = rx_shift;
        rx_push       = 1'b0;
        fe_set        = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_next = '0;
                if (rx_fall) begin
                    rx_div_next   = eff_div(divisor);
                    rx_state_next = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt == (rx_div >> 1) - 16'd1) begin
                    rx_cnt_next = '0;
                    rx_bit_next = '0;
                    rx_state_next = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == rx_div - 16'd1) begin
                    rx_cnt_next   = '0;
                    rx_shift_next = {rx_sync, rx_shift[7:1]};
                    if (rx_bit == 3'd7) begin
                        rx_state_next = RX_STOP;
                    end else begin
                        rx_bit_next = rx_bit + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (rx_cnt == rx_div - 16'd1) begin
                    rx_cnt_next   = '0;
                    rx_state_next = RX_IDLE;
                    rx_push       = rx_sync;
                    fe_set        = !rx_sync;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mm_spart.sv
// Self-checking bench for mm_spart: register-window vector table, TX waveform
// checks, loopback bursts against a queue model, and error/reset corner cases.
module tb_mm_spart;

    localparam logic [15:0] BASE   = 16'hC004;
    localparam logic [15:0] A_DATA = BASE;
    localparam logic [15:0] A_STAT = BASE + 16'd1;
    localparam logic [15:0] A_DIV  = BASE + 16'd2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mm_re = 1'b0;
    logic        mm_we = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [15:0] wdata = 16'h0000;
    logic [15:0] rdata;
    logic        tx;
    logic        rx;
    logic        loop = 1'b0;
    logic        rx_drv = 1'b1;

    int total = 0;
    int bad = 0;

    assign rx = loop ? tx : rx_drv;

    mm_spart #(.BASE_ADDR(BASE), .FIFO_DEPTH(8), .DB_RESET(16'd434)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr),
        .mm_re (mm_re),
        .mm_we (mm_we),
        .wdata (wdata),
        .rdata (rdata),
        .TX    (tx),
        .RX    (rx)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic        re;
        logic [15:0] addr;
        logic [15:0] wd;
        logic [15:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] stat(input logic fe, input logic ov, input int free, input int cnt);
        return {6'b0, fe, ov, 4'(free), 4'(cnt)};
    endfunction

    // One bus cycle; rdata is sampled mid-cycle, the edge then commits any side effects.
    task automatic cpu(input logic we, input logic re, input logic [15:0] a,
                       input logic [15:0] d, output logic [15:0] rd);
        @(negedge clk);
        addr = a; mm_we = we; mm_re = re; wdata = d;
        #1 rd = rdata;
        @(posedge clk);
        #1;
        mm_we = 1'b0; mm_re = 1'b0; addr = 16'h0000; wdata = 16'h0000;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        logic [15:0] dummy;
        cpu(1'b1, 1'b0, a, d, dummy);
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] v);
        cpu(1'b0, 1'b1, a, 16'h0000, v);
    endtask

    // Waits for a start bit, then checks every cycle of the 10-bit frame; optionally
    // writes DIVISOR during the start bit.
    task automatic check_tx_frame(input logic [7:0] b, input int div, input logic mid_wr,
                                  input logic [15:0] mid_val, input string tag);
        int n;
        logic [9:0] bits;
        logic ok;
        n = 0;
        bits = {1'b1, b, 1'b0};
        while (tx !== 1'b0 && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        if (tx !== 1'b0) begin
            check($sformatf("%s start timeout", tag), 16'(tx), 16'h0000);
            return;
        end
        for (int k = 0; k < 10; k++) begin
            ok = 1'b1;
            for (int j = 0; j < div; j++) begin
                if (tx !== bits[k]) ok = 1'b0;
                if (mid_wr && k == 0 && j == 4) begin
                    addr = A_DIV; wdata = mid_val; mm_we = 1'b1;
                end else begin
                    mm_we = 1'b0; addr = 16'h0000;
                end
                @(posedge clk); #1;
            end
            check($sformatf("%s bit%0d", tag, k), 16'(ok), 16'h0001);
        end
    endtask

    // Drives one frame onto RX by hand.
    task automatic send_rx(input logic [7:0] b, input logic stop, input int div);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rx_drv = bits[k];
            repeat (div) @(posedge clk);
        end
        rx_drv = 1'b1;
    endtask

    // Loopback burst of n random bytes with no CPU pops; the model is a queue of what
    // was sent, of which only the first FIFO-depth bytes survive.
    task automatic lb_burst(input int n, input logic [15:0] div, input string tag);
        logic [7:0] sent[$];
        logic [15:0] v;
        int eff, keep;
        eff = (div < 16'd16) ? 16 : int'(div);
        keep = (n > 8) ? 8 : n;
        loop = 1'b1;
        wr(A_DIV, div);
        for (int i = 0; i < n; i++) begin
            if (i >= 7) repeat (10 * eff + 5) @(posedge clk);
            sent.push_back(8'($urandom));
            wr(A_DATA, {8'h00, sent[i]});
        end
        repeat ((n + 1) * 10 * eff + 50) @(posedge clk);
        rd(A_STAT, v);
        check($sformatf("%s status n=%0d", tag, n), v, stat(1'b0, n > 8, 8, keep));
        rd(A_STAT, v);
        check($sformatf("%s sticky clear", tag), v, stat(1'b0, 1'b0, 8, keep));
        for (int i = 0; i < keep; i++) begin
            rd(A_DATA, v);
            check($sformatf("%s byte%0d", tag, i), v, {8'h00, sent[i]});
        end
        rd(A_DATA, v);
        check($sformatf("%s drained", tag), v, 16'h0000);
        loop = 1'b0;
    endtask

    initial begin
        vec_t vecs[16];
        logic [15:0] v;
        int n;

        vecs[0]  = '{we:1'b0, re:1'b1, addr:A_STAT,        wd:16'h0000, exp:16'h0080};
        vecs[1]  = '{we:1'b0, re:1'b1, addr:A_DIV,         wd:16'h0000, exp:16'h01B2};
        vecs[2]  = '{we:1'b0, re:1'b1, addr:A_DATA,        wd:16'h0000, exp:16'h0000};
        vecs[3]  = '{we:1'b0, re:1'b1, addr:BASE + 16'd3,  wd:16'h0000, exp:16'h0000};
        vecs[4]  = '{we:1'b0, re:1'b1, addr:BASE - 16'd1,  wd:16'h0000, exp:16'h0000};
        vecs[5]  = '{we:1'b0, re:1'b0, addr:A_DIV,         wd:16'h0000, exp:16'h0000};
        vecs[6]  = '{we:1'b1, re:1'b0, addr:A_DIV,         wd:16'h1234, exp:16'h0000};
        vecs[7]  = '{we:1'b0, re:1'b1, addr:A_DIV,         wd:16'h0000, exp:16'h1234};
        vecs[8]  = '{we:1'b1, re:1'b0, addr:A_STAT,        wd:16'hFFFF, exp:16'h0000};
        vecs[9]  = '{we:1'b0, re:1'b1, addr:A_STAT,        wd:16'h0000, exp:16'h0080};
        vecs[10] = '{we:1'b1, re:1'b0, addr:BASE + 16'd3,  wd:16'hFFFF, exp:16'h0000};
        vecs[11] = '{we:1'b0, re:1'b1, addr:A_DIV,         wd:16'h0000, exp:16'h1234};
        vecs[12] = '{we:1'b1, re:1'b0, addr:A_DIV,         wd:16'h0005, exp:16'h0000};
        vecs[13] = '{we:1'b0, re:1'b1, addr:A_DIV,         wd:16'h0000, exp:16'h0005};
        vecs[14] = '{we:1'b1, re:1'b0, addr:A_DIV,         wd:16'h0010, exp:16'h0000};
        vecs[15] = '{we:1'b0, re:1'b1, addr:A_DIV,         wd:16'h0000, exp:16'h0010};

        repeat (3) @(posedge clk);
        #1 check("reset tx idle", 16'(tx), 16'h0001);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            cpu(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wd, v);
            check($sformatf("vec%0d", i), v, vecs[i].exp);
        end

        // Single byte at divisor 16: exact waveform and TX FIFO occupancy.
        wr(A_DATA, 16'h0055);
        rd(A_STAT, v);
        check("tx_free after push", v, stat(1'b0, 1'b0, 7, 0));
        check_tx_frame(8'h55, 16, 1'b0, 16'h0000, "tx55");
        rd(A_STAT, v);
        check("tx_free after send", v, stat(1'b0, 1'b0, 8, 0));

        // Mid-frame divisor change applies only from the next frame.
        wr(A_DATA, 16'h00C6);
        wr(A_DATA, 16'h0039);
        check_tx_frame(8'hC6, 16, 1'b1, 16'd24, "txC6");
        check_tx_frame(8'h39, 24, 1'b0, 16'h0000, "tx39");
        rd(A_DIV, v);
        check("div after mid write", v, 16'd24);
        repeat (30) @(posedge clk);
        wr(A_DIV, 16'd16);

        // Loopback single byte.
        loop = 1'b1;
        wr(A_DATA, 16'h00A3);
        v = 16'h0000; n = 0;
        while (v[3:0] == 4'd0 && n < 400) begin
            rd(A_STAT, v); n++;
        end
        check("lb status", v, stat(1'b0, 1'b0, 8, 1));
        rd(A_DATA, v);
        check("lb data", v, 16'h00A3);
        rd(A_STAT, v);
        check("lb count zero", v, stat(1'b0, 1'b0, 8, 0));
        repeat (30) @(posedge clk);
        loop = 1'b0;

        // Nine bytes with no pops: overrun, ninth lost.
        lb_burst(9, 16'd16, "ovr9");

        // Random bursts, some with sub-floor divisors.
        for (int r = 0; r < 4; r++) begin
            lb_burst($urandom_range(1, 10), 16'($urandom_range(8, 24)), $sformatf("rnd%0d", r));
        end

        // Framing error, then a clean hand-driven frame.
        wr(A_DIV, 16'd16);
        send_rx(8'h3C, 1'b0, 16);
        repeat (40) @(posedge clk);
        rd(A_STAT, v);
        check("frame err set", v, stat(1'b1, 1'b0, 8, 0));
        rd(A_STAT, v);
        check("frame err clear", v, stat(1'b0, 1'b0, 8, 0));
        send_rx(8'h5A, 1'b1, 16);
        repeat (40) @(posedge clk);
        rd(A_DATA, v);
        check("manual rx byte", v, 16'h005A);

        // Empty read has no side effect; short glitch is rejected at divisor 434.
        rd(A_DATA, v);
        check("empty data read", v, 16'h0000);
        rd(A_STAT, v);
        check("status after empty read", v, stat(1'b0, 1'b0, 8, 0));
        wr(A_DIV, 16'd434);
        rx_drv = 1'b0;
        repeat (50) @(posedge clk);
        rx_drv = 1'b1;
        repeat (600) @(posedge clk);
        rd(A_STAT, v);
        check("glitch no byte", v, stat(1'b0, 1'b0, 8, 0));
        loop = 1'b1;
        wr(A_DATA, 16'h0096);
        repeat (10 * 434 + 100) @(posedge clk);
        rd(A_DATA, v);
        check("rx after glitch", v, 16'h0096);
        loop = 1'b0;

        // Reset in the middle of a frame with queued bytes.
        wr(A_DIV, 16'd16);
        loop = 1'b1;
        wr(A_DATA, 16'h0011);
        wr(A_DATA, 16'h0022);
        wr(A_DATA, 16'h0033);
        n = 0;
        while (tx !== 1'b0 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        repeat (5) @(posedge clk);
        #1 check("tx low before reset", 16'(tx), 16'h0000);
        #2 rst_n = 1'b0;
        #1 check("tx high on reset", 16'(tx), 16'h0001);
        @(negedge clk) rst_n = 1'b1;
        rd(A_STAT, v);
        check("status after reset", v, stat(1'b0, 1'b0, 8, 0));
        rd(A_DIV, v);
        check("div after reset", v, 16'd434);
        repeat (400) @(posedge clk);
        rd(A_STAT, v);
        check("no partial byte", v, stat(1'b0, 1'b0, 8, 0));
        loop = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mm_spart.md
MM_SPART -- requirements
Module: mm_spart

Interface
REQ-001 Parameter BASE_ADDR, 16'hC004, base address of the 3-register window (DATA=+0, STATUS=+1, DIVISOR=+2).
REQ-002 Parameter FIFO_DEPTH, 8, entries in each of the TX and RX FIFOs.
REQ-003 Parameter DB_RESET, 16'd434, reset value of the baud divisor.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 addr  input  16  CPU memory-mapped address, valid in the same cycle as mm_re/mm_we.
REQ-007 mm_re  input  1  external read strobe, one cycle per access.
REQ-008 mm_we  input  1  external write strobe, one cycle per access.
REQ-009 wdata  input  16  CPU store data.
REQ-010 rdata  output  16  read data, combinational from addr/mm_re.
REQ-011 TX  output  1  serial transmit line, idle high.
REQ-012 RX  input  1  asynchronous serial receive line, idle high.

Function
REQ-013 rdata SHALL be valid in the same cycle mm_re is high; it SHALL be 16'h0000 when mm_re is low or addr is outside the window.
REQ-014 DATA write SHALL push wdata[7:0] to the TX FIFO; the push SHALL be dropped when the FIFO is full, unless the transmitter dequeues in the same cycle.
REQ-015 DATA read SHALL return {8'h00, RX head} and pop at the clock edge; with the RX FIFO empty it SHALL return 16'h0000 and not pop.
REQ-016 STATUS read SHALL return {6'b0, frame_err, overrun, tx_free[3:0], rx_count[3:0]}; both sticky bits SHALL clear on the edge ending that read.
REQ-017 DIVISOR read/write SHALL access the 16-bit bit-period value in clocks; values below 16 SHALL behave as 16.
REQ-018 Writes to STATUS and outside the window SHALL be ignored.
REQ-019 TX FSM states IDLE, START, DATA, STOP; IDLE->START when the FIFO is non-empty (dequeue on this transition); START->DATA and STOP->IDLE after one bit period each; DATA shifts 8 bits LSB first.
REQ-020 TX line SHALL be low in START, the data bit in DATA, and high in STOP and IDLE.
REQ-021 RX SHALL pass through a 2-flop synchronizer before use.
REQ-022 RX FSM states IDLE, START, DATA, STOP; IDLE->START on a synchronized falling edge; START samples at half a bit period and returns to IDLE if high (false start).
REQ-023 DATA SHALL sample 8 bits at bit-period intervals, LSB first; STOP samples once, then the FSM returns to IDLE.
REQ-024 A stop bit sampled low SHALL discard the byte and set frame_err.
REQ-025 A valid byte arriving with the RX FIFO full SHALL be discarded and set overrun, unless a CPU pop occurs in the same cycle.
REQ-026 The divisor SHALL be latched at each frame's START entry (TX and RX independently); a mid-frame DIVISOR write SHALL affect only later frames.
REQ-027 Simultaneous push and pop on either FIFO SHALL both succeed and leave the count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-028 On rst_n low: both FIFOs empty, both FSMs IDLE, TX=1, divisor=DB_RESET, sticky bits 0, synchronizer flops 1.
REQ-029 Reset mid-frame SHALL abort the frame immediately, with no partial byte enqueued.

Structure
REQ-030 Package mm_spart_pkg SHALL hold register offsets, state enumerations and the minimum divisor constant.
REQ-031 A sub-module spart_fifo (parameterised depth and width, push/pop/full/empty/count) SHALL be instantiated twice.

Verification
REQ-032 DIVISOR=16, DATA write 0x55 -> TX low 16 clocks, then 1,0,1,0,1,0,1,0 at 16 clocks each, then high; STATUS tx_free reads 7 then 8.
REQ-033 TX looped back to RX, DIVISOR=16, write 0xA3 -> STATUS rx_count=1; DATA read 0x00A3, then rx_count=0.
REQ-034 Nine bytes received without popping -> rx_count=8, overrun=1 on the next STATUS read and 0 on the following one; the ninth byte is lost.
REQ-035 RX frame 0x3C with stop bit driven low -> rx_count=0, frame_err=1.
REQ-036 DATA read with RX empty -> rdata 16'h0000, STATUS unchanged; a 50-clock RX low glitch at DIVISOR=434 -> false start, no byte enqueued.
REQ-037 rst_n asserted in the middle of a TX byte -> TX=1 at once, tx_free=8, DIVISOR reads 434.
